// File: rtl/tsal_comparator.sv
// TSAL threshold comparator: samples an ADC result once per data_ready strobe and drives
// mutually exclusive red/green lamp enables, with optional multi-sample confirmation.
module tsal_comparator #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned CONFIRM_COUNT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_ready,
   input  logic [WIDTH-1:0] data,
   input  logic [WIDTH-1:0] in,
   output logic             red_enable,
   output logic             green_enable
);

   localparam int unsigned CW = (CONFIRM_COUNT > 1) ? $clog2(CONFIRM_COUNT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CONFIRM_COUNT - 1);

   typedef enum logic [1:0] {StIdle, StSafe, StActive} state_e;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            ready_q;
   logic            sample_event;
   logic            above;
   logic            disagree;

   assign sample_event = data_ready & ~ready_q;
   assign above        = (data >= in);
   assign disagree     = (above != (state_q == StActive));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         ready_q      <= 1'b0;
         red_enable   <= 1'b0;
         green_enable <= 1'b0;
      end else begin
         ready_q <= data_ready;
         if (sample_event) begin
            unique case (state_q)
               StIdle: begin
                  // First sample after reset sets the lamp without confirmation.
                  state_q      <= above ? StActive : StSafe;
                  red_enable   <= above;
                  green_enable <= ~above;
                  cnt_q        <= '0;
               end
               StSafe, StActive: begin
                  if (!disagree) begin
                     cnt_q <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q      <= above ? StActive : StSafe;
                     red_enable   <= above;
                     green_enable <= ~above;
                     cnt_q        <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q      <= StIdle;
                  red_enable   <= 1'b0;
                  green_enable <= 1'b0;
                  cnt_q        <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tsal_comparator.sv
// Directed bench for tsal_comparator: one instance with CONFIRM_COUNT=1 and one with 3,
// sharing the same clock, reset and stimulus.
`timescale 1ns/1ps
module tb_tsal_comparator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       data_ready = 1'b0;
   logic [7:0] data = '0;
   logic [7:0] thr = 8'd100;
   logic       red1, green1, red3, green3;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   always #62.5 clk = ~clk;

   tsal_comparator #(.WIDTH(8), .CONFIRM_COUNT(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_ready   (data_ready),
      .data         (data),
      .in           (thr),
      .red_enable   (red1),
      .green_enable (green1)
   );

   tsal_comparator #(.WIDTH(8), .CONFIRM_COUNT(3)) dut3 (
      .clk          (clk),
      .rst          (rst),
      .data_ready   (data_ready),
      .data         (data),
      .in           (thr),
      .red_enable   (red3),
      .green_enable (green3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Strobe high two cycles, low two cycles; inputs change on the falling edge.
   task automatic strobe(input logic [7:0] val);
      @(negedge clk);
      data       = val;
      data_ready = 1'b1;
      repeat (2) @(negedge clk);
      data_ready = 1'b0;
      repeat (1) @(negedge clk);
   endtask

   initial begin
      // Reset held 500 ns.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_during", {30'd0, red1, green1}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after_rst", {30'd0, red1, green1}, 32'd0);

      // 99: green one clock after the strobe is sampled, and holds after it falls.
      data       = 8'd99;
      data_ready = 1'b1;
      @(negedge clk);
      check("d99_first_edge", {30'd0, red1, green1}, 32'b01);
      @(negedge clk);
      data_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("d99_hold", {30'd0, red1, green1}, 32'b01);

      strobe(8'd100);
      check("d100_equal_red", {30'd0, red1, green1}, 32'b10);
      strobe(8'd255);
      check("d255_red", {30'd0, red1, green1}, 32'b10);
      strobe(8'd0);
      check("d0_green", {30'd0, red1, green1}, 32'b01);

      // Full sweep.
      for (int v = 0; v < 256; v++) begin
         strobe(8'(v));
         check($sformatf("sweep_%0d", v), {30'd0, red1, green1}, (v >= 100) ? 32'b10 : 32'b01);
      end

      // Long strobe: data changes after the first cycle; only 50 counts.
      @(negedge clk);
      data       = 8'd50;
      data_ready = 1'b1;
      @(negedge clk);
      data = 8'd150;
      repeat (3) @(negedge clk);
      data_ready = 1'b0;
      @(negedge clk);
      check("long_strobe_green", {30'd0, red1, green1}, 32'b01);

      // Threshold change without an event has no effect.
      strobe(8'd120);
      check("thr_before", {30'd0, red1, green1}, 32'b10);
      thr = 8'd200;
      repeat (3) @(negedge clk);
      check("thr_change_no_event", {30'd0, red1, green1}, 32'b10);
      thr = 8'd100;

      // Reset while red, with a simultaneous strobe.
      data       = 8'd150;
      data_ready = 1'b1;
      rst        = 1'b1;
      @(negedge clk);
      check("mid_rst_clears", {30'd0, red1, green1}, 32'd0);
      @(negedge clk);
      check("rst_overrides_strobe", {30'd0, red1, green1}, 32'd0);
      // Strobe still high as reset drops: event on the first edge after reset.
      rst = 1'b0;
      @(negedge clk);
      check("strobe_through_rst", {30'd0, red1, green1}, 32'b10);
      data_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Confirmation with CONFIRM_COUNT=3 starting from SAFE.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      strobe(8'd50);
      check("cc3_safe", {30'd0, red3, green3}, 32'b01);
      strobe(8'd150);
      check("cc1_switches_now", {30'd0, red1, green1}, 32'b10);
      check("cc3_s1", {30'd0, red3, green3}, 32'b01);
      strobe(8'd150);
      check("cc3_s2", {30'd0, red3, green3}, 32'b01);
      strobe(8'd50);
      check("cc3_s3_agree", {30'd0, red3, green3}, 32'b01);
      strobe(8'd150);
      check("cc3_s4", {30'd0, red3, green3}, 32'b01);
      strobe(8'd150);
      check("cc3_s5", {30'd0, red3, green3}, 32'b01);
      strobe(8'd150);
      check("cc3_s6_red", {30'd0, red3, green3}, 32'b10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
